ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment driver for an N-digit common-anode display.
- Accepts a packed hex value, a decimal-point mask and a blank mask through a load strobe.
- Scans the digits one at a time through a refresh divider.
- Shadow-buffers new values so a frame never shows mixed old and new digits. Sits between the datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4, digits driven; legal 1..8. Digit 0 is rightmost and least significant.
- REFRESH_DIV, 100000, clk cycles each digit is lit; legal >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle strobe that captures value, dp_in and blank_in.
- value  in  4*NUM_DIGITS  packed nibbles; nibble i drives digit i.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_in  in  NUM_DIGITS  1 = digit dark.
- pending  out  1  high from a load until that load is committed to the display.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.
- a_to_g  out  7  segments, active-low; bit6 = a … bit0 = g.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  digit enables, active-low, at most one low at a time.

Behaviour:
- Reset values: div_cnt = 0, idx = 0, all shadow and pending registers = 0, pending = 0, frame_done = 0, a_to_g = 7'b1111111, dp = 1, an = all ones.
- Refresh divider:
  - div_cnt counts 0..REFRESH_DIV-1. tick is asserted when div_cnt == REFRESH_DIV-1; div_cnt then wraps to 0.
  - On tick, idx increments, wrapping NUM_DIGITS-1 -> 0. The wrap sets frame_done for exactly that one cycle.
- Load and commit:
  - load writes value, dp_in and blank_in into the pending registers and sets pending.
  - A second load before commit overwrites the pending registers. Only the last load is committed.
  - Commit happens on the wrap tick: pending registers copy to shadow and pending clears. The new data is first shown on digit 0 of the next frame.
  - If load and the wrap tick occur in the same cycle, the load data bypasses straight into the shadow and pending ends 0.
  - If NUM_DIGITS = 1, every tick is a wrap.
- Output stage, registered: pins reflect idx and shadow one cycle after idx changes, so the an transition lags tick by 1 cycle.
  - an is low only at bit idx; all ones if that digit is blanked.
  - a_to_g = hex decode of nibble idx.
  - dp = ~dp_shadow[idx].
  - A blanked digit drives a_to_g = 7'b1111111 and dp = 1.
- Hex decode, a..g: 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100, A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000.
- Reset mid-scan forces the reset values immediately (asynchronously). Any pending load is discarded.

Optional Feature:
- Macro: SSD_LZB_EN (leading-zero blanking).
- Defined: any digit i > 0 with a zero nibble, and all digits above it also zero, is treated as blanked. This is computed from the shadow and ORed with blank_in. Digit 0 is never auto-blanked.
- Undefined: only blank_in blanks a digit.

Decomposition:
- ssd_pkg holds the 7-bit segment code constants (SEG_0..SEG_F, SEG_OFF = 7'b1111111) and the max-digit constant 8.
- One sub-module, ssd_hex_decode: a combinational 4-bit -> 7-bit lookup using the package constants.
- The divider, scan index, shadow, leading-zero logic and output registers stay in ssd_scan_driver.

Test Plan:
- Reset: hold rst with load active -> an = 4'b1111, a_to_g = 7'b1111111, dp = 1, pending = 0 throughout. After release, an = 4'b1110 one cycle later.
- Scan (N=4, REFRESH_DIV=4): an walks 1110 -> 1101 -> 1011 -> 0111, 4 cycles each. frame_done pulses once every 16 cycles, on the 3 -> 0 wrap.
- Decode: load value = 16'h12AF, dp_in = 4'b0100 -> digit0 0111000, digit1 0001000, digit2 0010010 with dp = 0, digit3 1001111.
- Commit: load 16'h1111 while digit 2 is lit -> pending = 1, and the old value stays on digits 2-3. From the next frame, all digits show 1001111 and pending = 0. Load on the wrap tick -> shown in the same frame, pending never rises.
- Blanking: blank_in = 4'b1010 -> an never low for digits 1 and 3.
- SSD_LZB_EN: value 16'h0030 -> digits 3 and 2 dark; digit 1 = 0000110; digit 0 = 0000001. Value 0 -> only digit 0 lit.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: segment codes
// (active-low, bit6 = a ... bit0 = g) and the widest supported display.
package ssd_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b1100000;
    localparam logic [6:0] SEG_C   = 7'b0110001;
    localparam logic [6:0] SEG_D   = 7'b1000010;
    localparam logic [6:0] SEG_E   = 7'b0110000;
    localparam logic [6:0] SEG_F   = 7'b0111000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-low seven-segment code lookup.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame-atomic
// value updates. Define SSD_LZB_EN to enable leading-zero blanking.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic                    pending,
    output logic                    frame_done,
    output logic [6:0]              a_to_g,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("ssd_scan_driver: NUM_DIGITS out of range");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("ssd_scan_driver: REFRESH_DIV must be at least 2");
    end

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank;

    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_eff;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;

    assign tick = (div_cnt == DIV_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;
            frame_done <= wrap;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // A load coinciding with the wrap tick bypasses straight into the shadow.
    // NOTE: the pending and shadow registers are reset explicitly so a display
    // reset mid-scan never shows stale digits or commits a discarded load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val     <= '0;
            pend_dp      <= '0;
            pend_blank   <= '0;
            pending      <= 1'b0;
            shadow_val   <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
        end else begin
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
            end
            if (wrap && (load || pending)) begin
                shadow_val   <= load ? value    : pend_val;
                shadow_dp    <= load ? dp_in    : pend_dp;
                shadow_blank <= load ? blank_in : pend_blank;
            end
            if (wrap) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib[i] = shadow_val[4*i +: 4];
        end
    end

    always_comb begin
        blank_eff = shadow_blank;
`ifdef SSD_LZB_EN
        begin : lzb
            logic upper_zero;
            upper_zero = 1'b1;
            // Walk down from the top digit; digit 0 is never auto-blanked.
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                upper_zero = upper_zero && (nib[i] == 4'h0);
                if (upper_zero) begin
                    blank_eff[i] = 1'b1;
                end
            end
        end
`endif
    end

    assign cur_nib = nib[idx];

    ssd_hex_decode u_dec (
        .nib (cur_nib),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an     <= '1;
            a_to_g <= SEG_OFF;
            dp     <= 1'b1;
        end else if (blank_eff[idx]) begin
            an     <= '1;
            a_to_g <= SEG_OFF;
            dp     <= 1'b1;
        end else begin
            an     <= ~(NUM_DIGITS'(1) << idx);
            a_to_g <= dec_seg;
            dp     <= ~shadow_dp[idx];
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (N=4, REFRESH_DIV=4): directed
// literal checks plus randomized loads compared every cycle to a frame model.
module tb_ssd_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic           clk      = 1'b0;
    logic           rst      = 1'b1;
    logic           load     = 1'b0;
    logic [4*N-1:0] value    = '0;
    logic [N-1:0]   dp_in    = '0;
    logic [N-1:0]   blank_in = '0;
    logic           pending;
    logic           frame_done;
    logic [6:0]     a_to_g;
    logic           dp;
    logic [N-1:0]   an;

    always #5 clk = ~clk;

    ssd_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .pending    (pending),
        .frame_done (frame_done),
        .a_to_g     (a_to_g),
        .dp         (dp),
        .an         (an)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Segment table written straight from the hex-decode list (0..F).
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: cycle count since reset decides the lit digit arithmetically.
    int             m_cyc   = 0;
    logic [4*N-1:0] m_pval  = '0, m_sval = '0;
    logic [N-1:0]   m_pdp   = '0, m_pbl = '0, m_sdp = '0, m_sbl = '0;
    bit             m_pflag = 1'b0;
    logic [N-1:0]   e_an    = '1;
    logic [6:0]     e_seg   = 7'h7f;
    logic           e_dp    = 1'b1;
    logic           e_fd    = 1'b0;
    logic           e_pend  = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        int             d;
        bit             wrap, blank, npf;
        logic [3:0]     nib;
        logic [4*N-1:0] npv;
        logic [N-1:0]   npd, npb;
        if (rst) begin
            m_cyc  <= 0;
            m_pval <= '0; m_pdp <= '0; m_pbl <= '0; m_pflag <= 1'b0;
            m_sval <= '0; m_sdp <= '0; m_sbl <= '0;
            e_an   <= '1; e_seg <= 7'h7f; e_dp <= 1'b1; e_fd <= 1'b0; e_pend <= 1'b0;
        end else begin
            d     = (m_cyc / DIV) % N;
            nib   = 4'((m_sval >> (4 * d)) & 16'hF);
            blank = m_sbl[d];
`ifdef SSD_LZB_EN
            if (d > 0 && (m_sval >> (4 * d)) == 0) blank = 1'b1;
`endif
            e_an  <= blank ? 4'hF : 4'(~(4'b0001 << d));
            e_seg <= blank ? 7'h7f : seg_tab[nib];
            e_dp  <= blank ? 1'b1 : ~m_sdp[d];
            wrap  = ((m_cyc % DIV) == DIV - 1) && (d == N - 1);
            e_fd  <= wrap;
            npv = load ? value    : m_pval;
            npd = load ? dp_in    : m_pdp;
            npb = load ? blank_in : m_pbl;
            npf = load | m_pflag;
            if (wrap && npf) begin
                m_sval <= npv; m_sdp <= npd; m_sbl <= npb;
                npf = 1'b0;
            end else if (wrap) begin
                npf = 1'b0;
            end
            m_pval <= npv; m_pdp <= npd; m_pbl <= npb; m_pflag <= npf;
            e_pend <= npf;
            m_cyc  <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("an", an, e_an);
            check("a_to_g", a_to_g, e_seg);
            check("dp", dp, e_dp);
            check("pending", pending, e_pend);
            check("frame_done", frame_done, e_fd);
        end
    end

    task automatic goto(input int k);
        int g = 0;
        while (m_cyc < k && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("goto_cycle", m_cyc, k);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp_in = d; blank_in = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; value = 16'h12AF; dp_in = 4'b0100; blank_in = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'b1111);
        check("rst_seg", a_to_g, 7'b1111111);
        check("rst_dp", dp, 1'b1);
        check("rst_pending", pending, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);

        rst = 1'b0; cmp_en = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("rel_an", an, 4'b1110);
        check("rel_seg", a_to_g, 7'b0000001);
        check("load_pending", pending, 1'b1);

        goto(15); check("fd_low", frame_done, 1'b0);
        goto(16); check("fd_wrap", frame_done, 1'b1); check("commit_clear", pending, 1'b0);
        goto(17); check("d0_F", a_to_g, 7'b0111000); check("d0_an", an, 4'b1110); check("d0_dp", dp, 1'b1);
        goto(21); check("d1_A", a_to_g, 7'b0001000); check("d1_an", an, 4'b1101);
        goto(25); check("d2_2", a_to_g, 7'b0010010); check("d2_dp", dp, 1'b0); check("d2_an", an, 4'b1011);
        goto(29); check("d3_1", a_to_g, 7'b1001111); check("d3_an", an, 4'b0111);
        goto(32); check("fd_wrap2", frame_done, 1'b1);

        goto(41); pulse_load(16'h1111, 4'b0000, 4'b0000);
        check("mid_old", a_to_g, 7'b0010010); check("mid_pending", pending, 1'b1);
        goto(49); check("new_frame", a_to_g, 7'b1001111); check("new_pending", pending, 1'b0);

        goto(63); pulse_load(16'h8888, 4'b0000, 4'b0000);
        check("wrap_nopend", pending, 1'b0);
        goto(65); check("wrap_bypass", a_to_g, 7'b0000000);

        goto(127); pulse_load(16'h0000, 4'b0000, 4'b1010);
        goto(133); check("blank_d1", an, 4'b1111);

        goto(159); pulse_load(16'h0030, 4'b0000, 4'b0000);
        goto(161); check("lz_d0_an", an, 4'b1110); check("lz_d0", a_to_g, 7'b0000001);
        goto(165); check("lz_d1", a_to_g, 7'b0000110); check("lz_d1_an", an, 4'b1101);
        goto(169);
`ifdef SSD_LZB_EN
        check("lz_d2_dark", an, 4'b1111);
`else
        check("lz_d2_lit", an, 4'b1011); check("lz_d2_seg", a_to_g, 7'b0000001);
`endif

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                load = 1'b0;
                #3 rst = 1'b1;
                #1;
                check("async_an", an, 4'b1111);
                check("async_seg", a_to_g, 7'b1111111);
                check("async_pending", pending, 1'b0);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                load     = ($urandom_range(0, 7) == 0);
                value    = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
                dp_in    = 4'($urandom);
                blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
                @(negedge clk);
            end
        end
        load = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
